// File: rtl/ex_mem_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_pkg
// Shared widths and opcodes for the EX/MEM pipeline register, plus the
// per-edge action selector used by the register's next-state logic.
// Exports:
//   REG_DATA_WIDTH / REG_ADDR_WIDTH / ALUOP_WIDTH - core datapath widths
//   STALL_WIDTH / STALL_EX / STALL_MEM            - stall vector layout
//   EXE_NOP_OP                                    - ALU opcode of a bubble
//   stage_action_e, select_action()               - per-edge register action
// ---------------------------------------------------------------------------
package ex_mem_reg_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALUOP_WIDTH    = 8;
  localparam int STALL_WIDTH    = 6;
  localparam int STALL_EX       = 3;
  localparam int STALL_MEM      = 4;
  localparam int HILO_TEMP_W    = 64;
  localparam int CNT_W          = 2;

  localparam logic [ALUOP_WIDTH-1:0] EXE_NOP_OP = 8'b0000_0000;

  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_action_e;

  // Flush beats every stall. An unstalled execute stage always captures,
  // which also covers the ex-running/mem-stalled combination the stall
  // controller never produces.
  function automatic stage_action_e select_action(input logic flush,
                                                  input logic ex_stall,
                                                  input logic mem_stall);
    stage_action_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (!ex_stall) begin
      act = ACT_CAPTURE;
    end else if (!mem_stall) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_if
// Bundle of everything crossing the EX/MEM boundary.
//   stall, flush          - pipeline control from the stall controller
//   ex_*                  - execute-stage results and memory operands
//   mem_*                 - the same fields, registered for the memory stage
//   hilo_temp_out/cnt_out - MADD/MSUB intermediate fed back to execute
// Modports: slave = the pipeline register, master = surrounding pipeline.
// ---------------------------------------------------------------------------
interface ex_mem_reg_if
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W  = REG_DATA_WIDTH,
  parameter int ADDR_W  = REG_ADDR_WIDTH,
  parameter int ALUOP_W = ALUOP_WIDTH,
  parameter int STALL_W = STALL_WIDTH
);

  logic [STALL_W-1:0]     stall;
  logic                   flush;

  logic [ADDR_W-1:0]      ex_w_reg_addr;
  logic [DATA_W-1:0]      ex_w_reg_data;
  logic                   ex_w_reg_en;
  logic [DATA_W-1:0]      ex_hi;
  logic [DATA_W-1:0]      ex_lo;
  logic                   ex_hilo_wen;
  logic [ALUOP_W-1:0]     ex_aluop;
  logic [DATA_W-1:0]      ex_mem_addr;
  logic [DATA_W-1:0]      ex_store_data;
  logic [HILO_TEMP_W-1:0] ex_hilo_temp;
  logic [CNT_W-1:0]       ex_cnt;

  logic [ADDR_W-1:0]      mem_w_reg_addr;
  logic [DATA_W-1:0]      mem_w_reg_data;
  logic                   mem_w_reg_en;
  logic [DATA_W-1:0]      mem_hi;
  logic [DATA_W-1:0]      mem_lo;
  logic                   mem_hilo_wen;
  logic [ALUOP_W-1:0]     mem_aluop;
  logic [DATA_W-1:0]      mem_mem_addr;
  logic [DATA_W-1:0]      mem_store_data;
  logic [HILO_TEMP_W-1:0] hilo_temp_out;
  logic [CNT_W-1:0]       cnt_out;

  modport slave (
    input  stall, flush,
    input  ex_w_reg_addr, ex_w_reg_data, ex_w_reg_en, ex_hi, ex_lo, ex_hilo_wen,
    input  ex_aluop, ex_mem_addr, ex_store_data, ex_hilo_temp, ex_cnt,
    output mem_w_reg_addr, mem_w_reg_data, mem_w_reg_en, mem_hi, mem_lo, mem_hilo_wen,
    output mem_aluop, mem_mem_addr, mem_store_data, hilo_temp_out, cnt_out
  );

  modport master (
    output stall, flush,
    output ex_w_reg_addr, ex_w_reg_data, ex_w_reg_en, ex_hi, ex_lo, ex_hilo_wen,
    output ex_aluop, ex_mem_addr, ex_store_data, ex_hilo_temp, ex_cnt,
    input  mem_w_reg_addr, mem_w_reg_data, mem_w_reg_en, mem_hi, mem_lo, mem_hilo_wen,
    input  mem_aluop, mem_mem_addr, mem_store_data, hilo_temp_out, cnt_out
  );

endinterface

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// EX/MEM pipeline register of the 5-stage MIPS core. Every output is a flop
// (one cycle from ex_* to mem_*). Per edge: flush clears everything; a
// bubble clears mem_* but advances the MADD/MSUB intermediate; an unstalled
// execute stage captures ex_* and clears the intermediate; otherwise hold.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous active-low reset, clears every output
//   bus   - ex_mem_reg_if.slave (stall, flush, ex_* in; mem_*, feedback out)
// ---------------------------------------------------------------------------
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W  = REG_DATA_WIDTH,
  parameter int ADDR_W  = REG_ADDR_WIDTH,
  parameter int ALUOP_W = ALUOP_WIDTH,
  parameter int STALL_W = STALL_WIDTH,
  parameter int EX_IDX  = STALL_EX,
  parameter int MEM_IDX = STALL_MEM
) (
  input logic         clk,
  input logic         rst_n,
  ex_mem_reg_if.slave bus
);

  localparam logic [ADDR_W-1:0]      ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0]      ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [HILO_TEMP_W-1:0] ZERO_TEMP = {HILO_TEMP_W{1'b0}};
  localparam logic [CNT_W-1:0]       ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [ALUOP_W-1:0]     NOP_OP    = ALUOP_W'(EXE_NOP_OP);

  stage_action_e act_s;

  logic [ADDR_W-1:0]      w_reg_addr_r,  w_reg_addr_s;
  logic [DATA_W-1:0]      w_reg_data_r,  w_reg_data_s;
  logic                   w_reg_en_r,    w_reg_en_s;
  logic [DATA_W-1:0]      hi_r,          hi_s;
  logic [DATA_W-1:0]      lo_r,          lo_s;
  logic                   hilo_wen_r,    hilo_wen_s;
  logic [ALUOP_W-1:0]     aluop_r,       aluop_s;
  logic [DATA_W-1:0]      mem_addr_r,    mem_addr_s;
  logic [DATA_W-1:0]      store_data_r,  store_data_s;
  logic [HILO_TEMP_W-1:0] hilo_temp_r,   hilo_temp_s;
  logic [CNT_W-1:0]       cnt_r,         cnt_s;

  assign act_s = select_action(bus.flush, bus.stall[EX_IDX], bus.stall[MEM_IDX]);

  // Next-state selection: start from hold, then apply the chosen action.
  always_comb begin
    w_reg_addr_s = w_reg_addr_r;
    w_reg_data_s = w_reg_data_r;
    w_reg_en_s   = w_reg_en_r;
    hi_s         = hi_r;
    lo_s         = lo_r;
    hilo_wen_s   = hilo_wen_r;
    aluop_s      = aluop_r;
    mem_addr_s   = mem_addr_r;
    store_data_s = store_data_r;
    hilo_temp_s  = hilo_temp_r;
    cnt_s        = cnt_r;
    case (act_s)
      ACT_FLUSH, ACT_BUBBLE: begin
        w_reg_addr_s = ZERO_ADDR;
        w_reg_data_s = ZERO_DATA;
        w_reg_en_s   = 1'b0;
        hi_s         = ZERO_DATA;
        lo_s         = ZERO_DATA;
        hilo_wen_s   = 1'b0;
        aluop_s      = NOP_OP;
        mem_addr_s   = ZERO_DATA;
        store_data_s = ZERO_DATA;
        // A bubble is how execute keeps a MADD/MSUB in flight: the
        // intermediate must advance even though mem sees a NOP.
        if (act_s == ACT_BUBBLE) begin
          hilo_temp_s = bus.ex_hilo_temp;
          cnt_s       = bus.ex_cnt;
        end else begin
          hilo_temp_s = ZERO_TEMP;
          cnt_s       = ZERO_CNT;
        end
      end
      ACT_CAPTURE: begin
        w_reg_addr_s = bus.ex_w_reg_addr;
        w_reg_data_s = bus.ex_w_reg_data;
        w_reg_en_s   = bus.ex_w_reg_en;
        hi_s         = bus.ex_hi;
        lo_s         = bus.ex_lo;
        hilo_wen_s   = bus.ex_hilo_wen;
        aluop_s      = bus.ex_aluop;
        mem_addr_s   = bus.ex_mem_addr;
        store_data_s = bus.ex_store_data;
        // Execute is moving on, so any finished multi-cycle op is retired.
        hilo_temp_s  = ZERO_TEMP;
        cnt_s        = ZERO_CNT;
      end
      ACT_HOLD: begin
        w_reg_addr_s = w_reg_addr_r;
      end
      default: begin
        w_reg_addr_s = w_reg_addr_r;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg_addr_r <= ZERO_ADDR;
      w_reg_data_r <= ZERO_DATA;
      w_reg_en_r   <= 1'b0;
      hi_r         <= ZERO_DATA;
      lo_r         <= ZERO_DATA;
      hilo_wen_r   <= 1'b0;
      aluop_r      <= NOP_OP;
      mem_addr_r   <= ZERO_DATA;
      store_data_r <= ZERO_DATA;
      hilo_temp_r  <= ZERO_TEMP;
      cnt_r        <= ZERO_CNT;
    end else begin
      w_reg_addr_r <= w_reg_addr_s;
      w_reg_data_r <= w_reg_data_s;
      w_reg_en_r   <= w_reg_en_s;
      hi_r         <= hi_s;
      lo_r         <= lo_s;
      hilo_wen_r   <= hilo_wen_s;
      aluop_r      <= aluop_s;
      mem_addr_r   <= mem_addr_s;
      store_data_r <= store_data_s;
      hilo_temp_r  <= hilo_temp_s;
      cnt_r        <= cnt_s;
    end
  end

  assign bus.mem_w_reg_addr = w_reg_addr_r;
  assign bus.mem_w_reg_data = w_reg_data_r;
  assign bus.mem_w_reg_en   = w_reg_en_r;
  assign bus.mem_hi         = hi_r;
  assign bus.mem_lo         = lo_r;
  assign bus.mem_hilo_wen   = hilo_wen_r;
  assign bus.mem_aluop      = aluop_r;
  assign bus.mem_mem_addr   = mem_addr_r;
  assign bus.mem_store_data = store_data_r;
  assign bus.hilo_temp_out  = hilo_temp_r;
  assign bus.cnt_out        = cnt_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
// Directed bench for ex_mem_reg. Each step drives ex_* and control, pushes
// the expected register contents to a queue, and after the clock edge pops
// and compares against the whole output bundle.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

  typedef struct packed {
    logic [4:0]  w_reg_addr;
    logic [31:0] w_reg_data;
    logic        w_reg_en;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_wen;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [63:0] hilo_temp;
    logic [1:0]  cnt;
  } obs_t;

  logic clk;
  logic rst_n;
  ex_mem_reg_if bus ();

  ex_mem_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  obs_t zero_v;
  obs_t p_v, q_v, b_v, t_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [4:0] a, input logic [31:0] d, input logic en,
                              input logic [31:0] hi, input logic [31:0] lo, input logic hwen,
                              input logic [7:0] op, input logic [31:0] ma, input logic [31:0] sd,
                              input logic [63:0] ht, input logic [1:0] c);
    obs_t v;
    v.w_reg_addr = a;  v.w_reg_data = d;  v.w_reg_en = en;
    v.hi = hi;         v.lo = lo;         v.hilo_wen = hwen;
    v.aluop = op;      v.mem_addr = ma;   v.store_data = sd;
    v.hilo_temp = ht;  v.cnt = c;
    return v;
  endfunction

  // Expected contents after a normal capture of stimulus s.
  function automatic obs_t captured(input obs_t s);
    obs_t v = s;
    v.hilo_temp = 64'h0;
    v.cnt       = 2'd0;
    return v;
  endfunction

  // Expected contents after a bubble edge with stimulus s.
  function automatic obs_t bubbled(input obs_t s);
    obs_t v = '0;
    v.hilo_temp = s.hilo_temp;
    v.cnt       = s.cnt;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t v;
    v.w_reg_addr = bus.mem_w_reg_addr;  v.w_reg_data = bus.mem_w_reg_data;
    v.w_reg_en   = bus.mem_w_reg_en;    v.hi         = bus.mem_hi;
    v.lo         = bus.mem_lo;          v.hilo_wen   = bus.mem_hilo_wen;
    v.aluop      = bus.mem_aluop;       v.mem_addr   = bus.mem_mem_addr;
    v.store_data = bus.mem_store_data;  v.hilo_temp  = bus.hilo_temp_out;
    v.cnt        = bus.cnt_out;
    return v;
  endfunction

  task automatic drive(input obs_t s, input logic [5:0] st, input logic fl);
    bus.stall         = st;
    bus.flush         = fl;
    bus.ex_w_reg_addr = s.w_reg_addr;  bus.ex_w_reg_data = s.w_reg_data;
    bus.ex_w_reg_en   = s.w_reg_en;    bus.ex_hi         = s.hi;
    bus.ex_lo         = s.lo;          bus.ex_hilo_wen   = s.hilo_wen;
    bus.ex_aluop      = s.aluop;       bus.ex_mem_addr   = s.mem_addr;
    bus.ex_store_data = s.store_data;  bus.ex_hilo_temp  = s.hilo_temp;
    bus.ex_cnt        = s.cnt;
  endtask

  task automatic compare(input string tag);
    obs_t got, exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=scoreboard-empty expected=one-entry", tag);
    end else begin
      exp = exp_q.pop_front();
      got = sample();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // The stall controller never lets execute run while mem is stalled.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.stall[3] === 1'b0 && bus.stall[4] === 1'b1) begin
      errors++;
      $error("FAIL illegal_stall: observed=%b expected=not(ex=0,mem=1)", bus.stall);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    zero_v = '0;
    p_v = mk(5'd8, 32'h1234_5678, 1'b1, 32'hAAAA_0001, 32'h5555_0002, 1'b0, 8'h23,
             32'h1000_0040, 32'hCAFE_BABE, 64'hDEAD_BEEF_0BAD_F00D, 2'd3);
    q_v = mk(5'd31, 32'h8765_4321, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 8'h2B,
             32'h2000_0084, 32'h0123_4567, 64'h1111_2222_3333_4444, 2'd2);
    b_v = mk(5'd17, 32'h7777_7777, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1, 8'h7A,
             32'h3000_0000, 32'h9999_9999, 64'h0000_0001_0000_0002, 2'd1);

    rst_n = 1'b0;
    drive(zero_v, 6'b000000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(zero_v);
    compare("reset_state");
    rst_n = 1'b1;

    // Pass-through, and no change before the edge
    drive(p_v, 6'b000000, 1'b0);
    #1;
    exp_q.push_back(zero_v);
    compare("no_comb_path");
    exp_q.push_back(captured(p_v));
    step("pass_through_p");
    drive(q_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(q_v));
    step("pass_through_q");

    // MADD bubble then completion
    drive(b_v, 6'b001111, 1'b0);
    exp_q.push_back(bubbled(b_v));
    step("madd_bubble");
    t_v = mk(5'd0, 32'h0, 1'b0, 32'h0000_0001, 32'h0000_0003, 1'b1, 8'h70,
             32'h0, 32'h0, 64'h5A5A_5A5A_A5A5_A5A5, 2'd2);
    drive(t_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(t_v));
    step("madd_finish");

    // Hold for three cycles with changing inputs
    drive(p_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(p_v));
    step("pre_hold_capture");
    for (int i = 0; i < 3; i++) begin
      t_v = mk(5'(i + 1), 32'($urandom), 1'b0, 32'($urandom), 32'($urandom), 1'b1,
               8'(i + 8'h40), 32'($urandom), 32'($urandom), {32'($urandom), 32'($urandom)}, 2'd1);
      drive(t_v, 6'b011111, 1'b0);
      exp_q.push_back(captured(p_v));
      step("hold");
    end

    // Bubble then hold keeps the in-flight intermediate
    drive(b_v, 6'b001111, 1'b0);
    exp_q.push_back(bubbled(b_v));
    step("bubble_before_hold");
    drive(q_v, 6'b011111, 1'b0);
    exp_q.push_back(bubbled(b_v));
    step("hold_keeps_cnt");

    // Flush over bubble, over capture, over hold
    drive(p_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(p_v));
    step("pre_flush_capture");
    drive(b_v, 6'b001111, 1'b0);
    exp_q.push_back(bubbled(b_v));
    step("pre_flush_bubble");
    drive(b_v, 6'b001111, 1'b1);
    exp_q.push_back(zero_v);
    step("flush_over_bubble");
    drive(q_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(q_v));
    step("post_flush_capture");
    drive(p_v, 6'b000000, 1'b1);
    exp_q.push_back(zero_v);
    step("flush_over_capture");
    drive(q_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(q_v));
    step("capture_before_hold_flush");
    drive(p_v, 6'b011111, 1'b1);
    exp_q.push_back(zero_v);
    step("flush_over_hold");

    // Asynchronous reset mid-cycle with non-zero outputs
    drive(p_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(p_v));
    step("pre_reset_capture");
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(zero_v);
    compare("async_reset_outputs");
    #2;
    rst_n = 1'b1;

    // Reset in the middle of a MADD, then normal capture
    drive(b_v, 6'b001111, 1'b0);
    exp_q.push_back(bubbled(b_v));
    step("pre_reset_madd");
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(zero_v);
    compare("reset_mid_madd");
    #2;
    rst_n = 1'b1;
    drive(q_v, 6'b000000, 1'b0);
    exp_q.push_back(captured(q_v));
    step("post_reset_capture");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
